// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI-bridge read arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;
  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/spi_read_arbiter_if.sv
// Requester command/response bundle plus the AXI4-Lite read channels toward the SPI bridge.
interface spi_read_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic [1:0]              rsp_resp;

  logic [ADDR_W-1:0]       araddr;
  logic                    arvalid;
  logic                    arready;
  logic [2:0]              arprot;
  logic [DATA_W-1:0]       rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    input  req_valid, req_addr, arready, rdata, rresp, rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arvalid, arprot, rready
  );

  modport slave (
    output req_valid, req_addr, arready, rdata, rresp, rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arvalid, arprot, rready
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_last_grant, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  output logic [N-1:0]  o_grant_oh,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any_req
);

  always_comb begin
    int            w_pos;
    logic [IW-1:0] w_idx;
    w_pos       = 0;
    w_idx       = '0;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any_req   = 1'b0;
    // N need not be a power of two, so wrap by subtraction rather than truncation.
    for (int k = 1; k <= N; k++) begin
      w_pos = int'(i_last_grant) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_idx = IW'(w_pos);
      if (!o_any_req && i_req[w_idx]) begin
        o_any_req         = 1'b1;
        o_grant_idx       = w_idx;
        o_grant_oh[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_read_arbiter.sv
// Round-robin sharing of one AXI4-Lite read master among N_REQ requesters,
// one transaction at a time, with a hung-slave timeout that answers SLVERR.
module spi_read_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  spi_read_arbiter_if.master bus,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IW      = $clog2(N_REQ);
  localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  state_t             r_state,       w_state_next;
  logic [IW-1:0]      r_grant,       w_grant_next;
  logic [IW-1:0]      r_last_grant,  w_last_grant_next;
  logic [ADDR_W-1:0]  r_araddr,      w_araddr_next;
  logic               r_arvalid,     w_arvalid_next;
  logic               r_rready,      w_rready_next;
  logic [N_REQ-1:0]   r_req_ready,   w_req_ready_next;
  logic [N_REQ-1:0]   r_rsp_valid,   w_rsp_valid_next;
  logic [DATA_W-1:0]  r_rsp_data,    w_rsp_data_next;
  logic [1:0]         r_rsp_resp,    w_rsp_resp_next;
  logic               r_timeout_err, w_timeout_err_next;
  logic               r_busy,        w_busy_next;
  logic [CNT_W-1:0]   r_cnt,         w_cnt_next;

  logic [ADDR_W-1:0]  w_req_addr [N_REQ];
  logic [N_REQ-1:0]   w_pick_oh;
  logic [IW-1:0]      w_pick_idx;
  logic               w_any_req;
  logic [N_REQ-1:0]   w_grant_oh;
  logic               w_to_hit;
  logic               w_to_fire;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
    assign w_req_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
  end

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant_oh   (w_pick_oh),
    .o_grant_idx  (w_pick_idx),
    .o_any_req    (w_any_req)
  );

  assign w_grant_oh = N_REQ'(1) << r_grant;
  assign w_to_hit   = TO_EN && (r_cnt == CNT_LIM);

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_last_grant_next  = r_last_grant;
    w_araddr_next      = r_araddr;
    w_arvalid_next     = r_arvalid;
    w_rready_next      = r_rready;
    w_req_ready_next   = '0;
    w_rsp_valid_next   = '0;
    w_rsp_data_next    = r_rsp_data;
    w_rsp_resp_next    = r_rsp_resp;
    w_timeout_err_next = 1'b0;
    w_cnt_next         = r_cnt;
    w_to_fire          = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_grant_next     = w_pick_idx;
          w_araddr_next    = w_req_addr[w_pick_idx];
          w_arvalid_next   = 1'b1;
          w_req_ready_next = w_pick_oh;
          w_cnt_next       = '0;
          w_state_next     = ADDR;
        end
      end
      ADDR: begin
        // A handshake landing on the limit cycle still wins over the timeout.
        if (r_arvalid && bus.arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_cnt_next     = '0;
          w_state_next   = DATA;
        end else if (w_to_hit) begin
          w_to_fire = 1'b1;
        end else if (TO_EN) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_rready && bus.rvalid) begin
          w_rready_next     = 1'b0;
          w_rsp_data_next   = bus.rdata;
          w_rsp_resp_next   = bus.rresp;
          w_rsp_valid_next  = w_grant_oh;
          w_last_grant_next = r_grant;
          w_state_next      = IDLE;
        end else if (w_to_hit) begin
          w_to_fire = 1'b1;
        end else if (TO_EN) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Dead slave: abandon the AXI phase and answer the requester with SLVERR.
    if (w_to_fire) begin
      w_arvalid_next     = 1'b0;
      w_rready_next      = 1'b0;
      w_rsp_data_next    = '0;
      w_rsp_resp_next    = RESP_SLVERR;
      w_rsp_valid_next   = w_grant_oh;
      w_timeout_err_next = 1'b1;
      w_last_grant_next  = r_grant;
      w_state_next       = IDLE;
    end

    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_last_grant  <= IW'(N_REQ - 1);
      r_araddr      <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_last_grant  <= w_last_grant_next;
      r_araddr      <= w_araddr_next;
      r_arvalid     <= w_arvalid_next;
      r_rready      <= w_rready_next;
      r_req_ready   <= w_req_ready_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_data    <= w_rsp_data_next;
      r_rsp_resp    <= w_rsp_resp_next;
      r_timeout_err <= w_timeout_err_next;
      r_busy        <= w_busy_next;
      r_cnt         <= w_cnt_next;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_resp  = r_rsp_resp;
  assign bus.araddr    = r_araddr;
  assign bus.arvalid   = r_arvalid;
  assign bus.arprot    = ARPROT_DEFAULT;
  assign bus.rready    = r_rready;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_spi_read_arbiter.sv
// Bench for spi_read_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level round-robin model.
module tb_spi_read_arbiter;
  import spi_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [N*AW-1:0] ADDRS = {24'h000400, 24'h000300, 24'h000200, 24'h0000A0};

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  logic busy;
  logic timeout_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  spi_read_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  spi_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic [N-1:0]    exp_oh;
    logic [AW-1:0]   exp_araddr;
  } vec_t;
  vec_t vt [8];

  // random-run model state
  int            st [N];        // 0 idle, 1 requesting, 2 granted
  logic [AW-1:0] raddr [N];
  int            outst, model_last, exp_i, n_rsp;
  int            ar_cnt, ar_dly, r_cnt, r_dly;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_resp;
  int            ng, last_cyc, kk;

  task automatic tick();
    @(negedge ACLK);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    ARESETn       = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.arready   = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = '0;
    bus.rvalid    = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    chk(name, busy, 1'b0);
  endtask

  // Spec rule: first pending requester strictly after the last one served, circularly.
  function automatic int rr_expect(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  initial begin
    vt[0] = '{4'b0001, ADDRS, 32'hCAFE0001, 2'b00, 4'b0001, 24'h0000A0};
    vt[1] = '{4'b1001, ADDRS, 32'h11112222, 2'b01, 4'b1000, 24'h000400};
    vt[2] = '{4'b1001, ADDRS, 32'h33334444, 2'b00, 4'b0001, 24'h0000A0};
    vt[3] = '{4'b0110, ADDRS, 32'h55556666, 2'b11, 4'b0010, 24'h000200};
    vt[4] = '{4'b0110, ADDRS, 32'h77778888, 2'b10, 4'b0100, 24'h000300};
    vt[5] = '{4'b0011, ADDRS, 32'h9999AAAA, 2'b00, 4'b0001, 24'h0000A0};
    vt[6] = '{4'b1111, ADDRS, 32'hBBBBCCCC, 2'b01, 4'b0010, 24'h000200};
    vt[7] = '{4'b0100, ADDRS, 32'hDDDDEEEE, 2'b00, 4'b0100, 24'h000300};

    // ---------------- reset state ----------------
    ARESETn = 1'b0;
    bus.req_valid = 4'b1111; bus.req_addr = ADDRS;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = '1; bus.rresp = 2'b11;
    tick(); tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_resp", bus.rsp_resp, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_arprot", bus.arprot, 0);
    do_reset();

    // ---------------- table vectors, slave always ready ----------------
    for (int v = 0; v < 8; v++) begin
      bus.arready = 1'b1; bus.rvalid = 1'b1;
      bus.rdata = vt[v].rdata; bus.rresp = vt[v].rresp;
      bus.req_addr = vt[v].addr; bus.req_valid = vt[v].req;
      tick();
      chk("vec_req_ready", bus.req_ready, vt[v].exp_oh);
      chk("vec_araddr", bus.araddr, vt[v].exp_araddr);
      chk("vec_arvalid", bus.arvalid, 1);
      chk("vec_busy", busy, 1);
      bus.req_valid = '0;
      tick();
      chk("vec_rready", bus.rready, 1);
      chk("vec_arvalid_low", bus.arvalid, 0);
      chk("vec_req_ready_pulse", bus.req_ready, 0);
      tick();
      chk("vec_rsp_valid", bus.rsp_valid, vt[v].exp_oh);
      chk("vec_rsp_data", bus.rsp_data, vt[v].rdata);
      chk("vec_rsp_resp", bus.rsp_resp, vt[v].rresp);
      chk("vec_rready_low", bus.rready, 0);
      chk("vec_idle", busy, 0);
      $display("vec %0d: req=%b grant=%b araddr=%h rsp_data=%h", v, vt[v].req, vt[v].exp_oh, bus.araddr, bus.rsp_data);
    end

    // ---------------- all four requesting continuously ----------------
    do_reset();
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = '0; bus.rresp = 2'b00;
    bus.req_addr = {24'h000040, 24'h000030, 24'h000020, 24'h000010};
    bus.req_valid = 4'b1111;
    ng = 0; kk = 0; last_cyc = 0;
    while (ng < 5 && kk < 40) begin
      tick();
      kk++;
      chk("cont_rsp_onehot", $onehot0(bus.rsp_valid), 1'b1);
      if (bus.req_ready != '0) begin
        chk("cont_grant", bus.req_ready, 64'd1 << (ng % 4));
        chk("cont_araddr", bus.araddr, 24'h10 * ((ng % 4) + 1));
        if (ng > 0) chk("cont_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        ng++;
        $display("cont txn %0d: grant=%b araddr=%h", ng, bus.req_ready, bus.araddr);
      end
    end
    bus.req_valid = '0;
    chk("cont_count", ng, 5);
    wait_idle("cont_idle");

    // ---------------- back-pressure: arready low 5, rvalid 3 late ----------------
    bus.arready = 1'b0; bus.rvalid = 1'b0;
    bus.req_addr = '0; bus.req_addr[2*AW +: AW] = 24'hABC123;
    bus.req_valid = 4'b0100;
    tick();
    chk("bp_grant", bus.req_ready, 4'b0100);
    bus.req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      chk("bp_arvalid", bus.arvalid, 1);
      chk("bp_araddr", bus.araddr, 24'hABC123);
    end
    bus.arready = 1'b1;
    tick();
    chk("bp_ar_done", bus.arvalid, 0);
    bus.arready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      chk("bp_rready", bus.rready, 1);
      chk("bp_no_rsp", bus.rsp_valid, 0);
    end
    bus.rvalid = 1'b1; bus.rdata = 32'hBEEF0002; bus.rresp = RESP_OKAY;
    tick();
    chk("bp_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("bp_rsp_data", bus.rsp_data, 32'hBEEF0002);
    chk("bp_rready_low", bus.rready, 0);
    bus.rvalid = 1'b0;
    tick();
    chk("bp_single_pulse", bus.rsp_valid, 0);
    chk("bp_idle", busy, 0);
    $display("bp txn: requester 2 araddr=ABC123 done");

    // ---------------- timeout with arready stuck low ----------------
    bus.req_addr = {24'h000DDD, 24'h000000, 24'h000BBB, 24'h000000};
    bus.req_valid = 4'b1010;
    tick();
    chk("to_grant", bus.req_ready, 4'b1000);
    bus.req_valid = 4'b0010;
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("to_arvalid_hold", bus.arvalid, 1);
      chk("to_no_err_yet", timeout_err, 0);
      chk("to_no_rsp_yet", bus.rsp_valid, 0);
    end
    tick();
    chk("to_arvalid_drop", bus.arvalid, 0);
    chk("to_rsp_valid", bus.rsp_valid, 4'b1000);
    chk("to_rsp_resp", bus.rsp_resp, RESP_SLVERR);
    chk("to_rsp_data", bus.rsp_data, 0);
    chk("to_err_pulse", timeout_err, 1);
    chk("to_idle", busy, 0);
    $display("to txn: requester 3 timed out");
    tick();
    chk("to_err_single", timeout_err, 0);
    chk("to_next_grant", bus.req_ready, 4'b0010);
    chk("to_next_araddr", bus.araddr, 24'h000BBB);
    bus.req_valid = '0;

    // ---------------- handshake on the limit cycle ----------------
    for (int k = 12; k <= 19; k++) begin
      tick();
      chk("col_arvalid_hold", bus.arvalid, 1);
    end
    bus.arready = 1'b1;
    tick();
    chk("col_no_timeout", timeout_err, 0);
    chk("col_no_rsp", bus.rsp_valid, 0);
    chk("col_rready", bus.rready, 1);
    chk("col_arvalid_low", bus.arvalid, 0);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h12345678; bus.rresp = RESP_OKAY;
    tick();
    chk("col_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("col_rsp_data", bus.rsp_data, 32'h12345678);
    chk("col_rsp_resp", bus.rsp_resp, RESP_OKAY);
    chk("col_no_err", timeout_err, 0);
    bus.rvalid = 1'b0;
    $display("col txn: requester 1 completed normally");

    // ---------------- asynchronous reset mid-DATA ----------------
    bus.req_addr = '0; bus.req_addr[2*AW +: AW] = 24'h000777;
    bus.req_valid = 4'b0100; bus.arready = 1'b1;
    tick();
    chk("ar_grant", bus.req_ready, 4'b0100);
    bus.req_valid = '0;
    tick();
    chk("ar_in_data", bus.rready, 1);
    chk("ar_busy", busy, 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("ar_rready_clr", bus.rready, 0);
    chk("ar_busy_clr", busy, 0);
    chk("ar_rsp_clr", bus.rsp_valid, 0);
    chk("ar_arvalid_clr", bus.arvalid, 0);
    bus.arready = 1'b0;
    bus.req_addr = {24'h000333, 24'h000000, 24'h000000, 24'h000111};
    bus.req_valid = 4'b1001;
    tick();
    ARESETn = 1'b1;
    tick();
    chk("ar_first_grant", bus.req_ready, 4'b0001);
    chk("ar_first_araddr", bus.araddr, 24'h000111);
    bus.req_valid = '0; bus.arready = 1'b1; bus.rvalid = 1'b1;
    wait_idle("ar_idle");
    $display("ar txn: requester 0 granted first after reset");

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int i = 0; i < N; i++) begin st[i] = 0; raddr[i] = '0; end
    outst = -1; model_last = N - 1; n_rsp = 0;
    ar_cnt = 0; ar_dly = 0; r_cnt = 0; r_dly = 0;
    exp_data = '0; exp_resp = '0;
    kk = 0;
    while (n_rsp < 150 && kk < 4000) begin
      tick();
      kk++;
      chk("rnd_no_timeout", timeout_err, 0);
      if (bus.req_ready != '0) begin
        exp_i = rr_expect(bus.req_valid, model_last);
        chk("rnd_no_overlap", outst, -1);
        if (exp_i < 0) begin
          chk("rnd_spurious_grant", bus.req_ready, 0);
        end else begin
          chk("rnd_grant", bus.req_ready, 64'd1 << exp_i);
          chk("rnd_araddr", bus.araddr, raddr[exp_i]);
          st[exp_i] = 2;
          bus.req_valid[exp_i] = 1'b0;
        end
        outst = exp_i;
      end
      if (bus.rsp_valid != '0) begin
        chk("rnd_rsp_valid", bus.rsp_valid, (outst >= 0) ? (64'd1 << outst) : 64'd0);
        chk("rnd_rsp_data", bus.rsp_data, exp_data);
        chk("rnd_rsp_resp", bus.rsp_resp, exp_resp);
        $display("rnd txn %0d: requester %0d data=%h resp=%0d", n_rsp, outst, bus.rsp_data, bus.rsp_resp);
        if (outst >= 0) begin
          st[outst] = 0;
          model_last = outst;
        end
        outst = -1;
        n_rsp++;
      end
      for (int i = 0; i < N; i++) begin
        if (st[i] == 0 && $urandom_range(0, 2) == 0) begin
          st[i] = 1;
          raddr[i] = AW'($urandom);
          bus.req_valid[i] = 1'b1;
          bus.req_addr[i*AW +: AW] = raddr[i];
        end
      end
      if (bus.arvalid) begin
        bus.arready = (ar_cnt >= ar_dly);
        ar_cnt++;
      end else begin
        bus.arready = 1'b0;
        ar_cnt = 0;
        ar_dly = $urandom_range(0, 4);
      end
      if (bus.rready) begin
        if (r_cnt >= r_dly) begin
          if (!bus.rvalid) begin
            bus.rdata = $urandom;
            bus.rresp = 2'($urandom_range(0, 3));
            exp_data = bus.rdata;
            exp_resp = bus.rresp;
          end
          bus.rvalid = 1'b1;
        end else begin
          bus.rvalid = 1'b0;
        end
        r_cnt++;
      end else begin
        bus.rvalid = 1'b0;
        r_cnt = 0;
        r_dly = $urandom_range(0, 4);
      end
    end
    chk("rnd_completed", (n_rsp >= 150), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_read_arbiter.md
Name: spi_read_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Lite read master port toward the SPI bridge slave between N_REQ independent read requesters.
- Each requester issues a simple valid/ready read command carrying an address, and gets back a one-cycle response pulse with data and response code.
- Sequences exactly one AXI read transaction at a time, address phase then data phase.
- Includes a hung-slave timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 24, read address width.
- DATA_W, 32, read data width.
- TIMEOUT_CYC, 255, max cycles waiting in the address or data phase before forced completion; 0 disables the timeout.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester read request.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_ready  out  N_REQ  one-hot accept pulse.
- rsp_valid  out  N_REQ  one-hot response pulse.
- rsp_data  out  DATA_W  response data; shared, valid with rsp_valid.
- rsp_resp  out  2  AXI response code; shared, valid with rsp_valid.
- araddr  out  ADDR_W  AXI read address.
- arvalid  out  1  AXI read address valid.
- arready  in  1  AXI read address ready.
- arprot  out  3  tied to 3'b000.
- rdata  in  DATA_W  AXI read data.
- rresp  in  2  AXI read response.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  one-cycle pulse when a timeout completes a transaction.

Behaviour:
- Clock and reset: one clock, ACLK. Reset is asynchronous and active-low (ARESETn). All flops clear on ARESETn low, regardless of ACLK.
- Reset values:
  - req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arvalid, rready, busy, timeout_err all 0.
  - state IDLE; last_grant = N_REQ-1, so requester 0 wins first; timeout counter 0.
- Reset mid-transaction: the transaction is abandoned with no response. Requesters must re-issue after reset.
- All outputs are registered.
- States: IDLE, ADDR, DATA.
- IDLE:
  - When any req_valid is set, the picker selects the first set bit searching from (last_grant+1) mod N_REQ upward with wrap.
  - Registered on that edge: grant index, araddr = selected req_addr slice, arvalid=1, req_ready[grant]=1 for one cycle. Then go to ADDR.
  - With no request, stay in IDLE; outputs hold 0.
- ADDR:
  - arvalid and araddr are held stable until arvalid && arready.
  - On that handshake: arvalid<=0, rready<=1, go to DATA.
  - req_ready returns to 0 after its single cycle.
- DATA:
  - rready is held 1 until rvalid && rready.
  - On that handshake: rready<=0, rsp_data<=rdata, rsp_resp<=rresp, rsp_valid[grant]<=1 for one cycle, last_grant<=grant, go to IDLE.
- Timeout:
  - The counter clears on entry to ADDR and to DATA, and increments each cycle the phase handshake is absent.
  - When it reaches TIMEOUT_CYC: arvalid<=0, rready<=0, rsp_data<=0, rsp_resp<=2'b10 (SLVERR), rsp_valid[grant] pulse, timeout_err pulse, last_grant<=grant, go to IDLE.
  - This is a documented recovery deviation from AXI for a dead slave.
- Handshake completing in the same cycle the counter hits TIMEOUT_CYC: the handshake wins, and the normal response is returned.
- Requester contract: hold req_valid and req_addr until req_ready is seen.
  - A request withdrawn after being latched still completes, and its rsp_valid is still pulsed.
- Minimum latency with arready and rvalid both tied high:
  - req seen in IDLE at T0; arvalid=1 at T1; rready=1 at T2; rsp_valid at T3.
  - Next grant decision at T3; next arvalid at T4.
  - Sustained throughput is 1 read per 3 cycles.
- Fairness: a requester holding req_valid is served within N_REQ transactions.
- Only one grant is outstanding. No AR/R overlap and no pipelining.
- Width rules:
  - grant index is $clog2(N_REQ) bits.
  - The wrap in the search is modulo N_REQ, which need not be a power of two.
  - The timeout counter is $clog2(TIMEOUT_CYC+1) bits, minimum 1.

Decomposition:
- Package spi_arb_pkg:
  - state enum {IDLE, ADDR, DATA}.
  - localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - ARPROT_DEFAULT=3'b000.
- Sub-module rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: req vector, last_grant. Outputs: one-hot grant, grant index, any_req.
  - Instantiated once and reusable by other arbiters.

Test Plan:
- Single read, slave with arready=rvalid=1 and rdata=32'hCAFE0001:
  - req_valid=4'b0001, req_addr[0]=24'h0000A0.
  - Expect req_ready[0] at T1 with araddr=24'h0000A0.
  - Expect rsp_valid=4'b0001 at T3 with rsp_data=32'hCAFE0001, rsp_resp=0.
- All four requesting continuously with addresses 24'h10/20/30/40:
  - Grant order 0,1,2,3,0, and araddr sequence 10,20,30,40,10.
  - No rsp_valid bit is ever more than one-hot.
- Back-pressure, arready low 5 cycles then rvalid delayed 3 cycles:
  - arvalid and araddr stay stable for 6 cycles; rready stays high 4 cycles.
  - A single rsp_valid pulse follows.
- Timeout with TIMEOUT_CYC=8 and arready stuck at 0:
  - After 8 cycles: arvalid drops, rsp_valid[grant] pulses with rsp_resp=2'b10 and rsp_data=0.
  - timeout_err pulses; the next requester is granted.
- Handshake versus timeout collision:
  - arready rises exactly on the cycle the counter reaches TIMEOUT_CYC.
  - Normal DATA phase follows; no timeout_err.
- Asynchronous reset mid-DATA:
  - ARESETn low between clock edges clears rready, busy and rsp_valid immediately.
  - After release, requester 0 with req_valid=4'b1001 is granted first.
